// File: rtl/simon_sequencer_if.sv
// rtl/simon_sequencer_if.sv - game-side signal bundle for simon_sequencer
//
// master : drives start/btn/rnd, observes the display outputs
// slave  : the sequencer itself (consumes start/btn/rnd, drives led/level/busy/win/lose)
// level is $clog2(MAX_LEN+1) bits wide; MAX_LEN must match the sequencer's.
interface simon_sequencer_if #(
    parameter int MAX_LEN = 16
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic          start;
    logic [3:0]    btn;
    logic [1:0]    rnd;
    logic [3:0]    led;
    logic [LW-1:0] level;
    logic          busy;
    logic          win;
    logic          lose;

    modport master (
        output start, btn, rnd,
        input  led, level, busy, win, lose
    );

    modport slave (
        input  start, btn, rnd,
        output led, level, busy, win, lose
    );
endinterface

// File: rtl/simon_sequencer.sv
// rtl/simon_sequencer.sv - memory-game controller: grows, plays back and checks a colour sequence
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : simon_sequencer_if.slave
//            start (game start pulse), btn[3:0] (press pulses), rnd[1:0] (random colour),
//            led[3:0] (registered one-hot display), level (current sequence length),
//            busy / win / lose status
module simon_sequencer #(
    parameter int MAX_LEN    = 16,
    parameter int SHOW_TICKS = 25000000,
    parameter int GAP_TICKS  = 12500000,
    parameter int LW         = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    simon_sequencer_if.slave bus
);

    localparam int IW   = $clog2(MAX_LEN);
    localparam int MAXT = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_WAIT_IN,
        S_WIN,
        S_LOSE
    } state_t;

    state_t        state, state_d;
    logic [LW-1:0] len, len_d;
    logic [IW-1:0] idx, idx_d;
    logic [TW-1:0] tick, tick_d;
    logic [3:0]    led, led_d;
    logic [1:0]    seq [MAX_LEN];
    logic          seq_we;

    logic [IW-1:0] next_idx;
    logic          last_step;
    logic [1:0]    first_col;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    assign next_idx  = idx + IW'(1);
    assign last_step = (LW'(idx) == len - LW'(1));
    // On the first round seq[0] is being written on the same edge that lights
    // the LED, so the colour has to come straight from rnd.
    assign first_col = (len == '0) ? bus.rnd : seq[0];

    always_comb begin
        state_d = state;
        len_d   = len;
        idx_d   = idx;
        tick_d  = tick;
        led_d   = led;
        seq_we  = 1'b0;

        case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (bus.start) begin
                    len_d   = '0;
                    idx_d   = '0;
                    led_d   = 4'b0000;
                    state_d = S_ADD;
                end
            end

            S_ADD: begin
                seq_we  = 1'b1;
                len_d   = len + LW'(1);
                idx_d   = '0;
                tick_d  = '0;
                led_d   = onehot(first_col);
                state_d = S_SHOW_ON;
            end

            S_SHOW_ON: begin
                if (tick == TW'(SHOW_TICKS - 1)) begin
                    tick_d  = '0;
                    led_d   = 4'b0000;
                    state_d = S_SHOW_OFF;
                end else begin
                    tick_d = tick + TW'(1);
                end
            end

            S_SHOW_OFF: begin
                if (tick == TW'(GAP_TICKS - 1)) begin
                    tick_d = '0;
                    if (last_step) begin
                        idx_d   = '0;
                        state_d = S_WAIT_IN;
                    end else begin
                        idx_d   = next_idx;
                        // led is registered, so load the next colour as we leave the gap
                        led_d   = onehot(seq[next_idx]);
                        state_d = S_SHOW_ON;
                    end
                end else begin
                    tick_d = tick + TW'(1);
                end
            end

            S_WAIT_IN: begin
                // The expected value is one-hot, so any multi-bit press also fails here.
                if (bus.btn != 4'b0000) begin
                    if (bus.btn != onehot(seq[idx])) begin
                        state_d = S_LOSE;
                    end else if (!last_step) begin
                        idx_d = next_idx;
                    end else if (len == LW'(MAX_LEN)) begin
                        led_d   = 4'b1111;
                        state_d = S_WIN;
                    end else begin
                        state_d = S_ADD;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            len   <= '0;
            idx   <= '0;
            tick  <= '0;
            led   <= 4'b0000;
        end else begin
            state <= state_d;
            len   <= len_d;
            idx   <= idx_d;
            tick  <= tick_d;
            led   <= led_d;
        end
    end

    // Sequence storage holds no meaningful value before a game, so it is not reset.
    always_ff @(posedge clk) begin
        if (seq_we) begin
            seq[len[IW-1:0]] <= bus.rnd;
        end
    end

    assign bus.led   = led;
    assign bus.level = len;
    assign bus.busy  = (state != S_IDLE) && (state != S_WIN) && (state != S_LOSE);
    assign bus.win   = (state == S_WIN);
    assign bus.lose  = (state == S_LOSE);

endmodule

// File: tb/tb_simon_sequencer.sv
// tb/tb_simon_sequencer.sv - self-checking bench for simon_sequencer
module tb_simon_sequencer;

    localparam int ML = 3;
    localparam int ST = 4;
    localparam int GT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    simon_sequencer_if #(.MAX_LEN(ML)) bus ();

    simon_sequencer #(
        .MAX_LEN   (ML),
        .SHOW_TICKS(ST),
        .GAP_TICKS (GT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef enum {M_IDLE, M_ADD, M_PLAY, M_WAIT, M_WIN, M_LOSE} mmode_t;

    mmode_t mode = M_IDLE;
    int     seq[$];
    int     t   = 0;
    int     pos = 0;

    int checks = 0;
    int errors = 0;

    function automatic logic [3:0] onehot(input int c);
        return 4'(1 << c);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game-level model: playback is a timeline of len*(ST+GT) cycles where step k
    // is lit during [k*(ST+GT), k*(ST+GT)+ST).
    task automatic model_update();
        if (!rst_n) begin
            mode = M_IDLE;
            seq.delete();
            t   = 0;
            pos = 0;
            return;
        end
        case (mode)
            M_IDLE, M_WIN, M_LOSE: begin
                if (bus.start) begin
                    seq.delete();
                    mode = M_ADD;
                end
            end
            M_ADD: begin
                seq.push_back(int'(bus.rnd));
                t    = 0;
                mode = M_PLAY;
            end
            M_PLAY: begin
                t++;
                if (t == seq.size() * (ST + GT)) begin
                    pos  = 0;
                    mode = M_WAIT;
                end
            end
            M_WAIT: begin
                if (bus.btn != 4'b0000) begin
                    if (bus.btn != onehot(seq[pos])) begin
                        mode = M_LOSE;
                    end else if (pos == seq.size() - 1) begin
                        mode = (seq.size() == ML) ? M_WIN : M_ADD;
                    end else begin
                        pos++;
                    end
                end
            end
            default: mode = M_IDLE;
        endcase
    endtask

    task automatic compare();
        logic [3:0] eled;
        eled = 4'b0000;
        if (mode == M_PLAY && (t % (ST + GT)) < ST) eled = onehot(seq[t / (ST + GT)]);
        if (mode == M_WIN) eled = 4'b1111;
        chk("led", 32'(bus.led), 32'(eled));
        chk("level", 32'(bus.level), 32'(seq.size()));
        chk("busy", 32'(bus.busy), 32'(mode == M_ADD || mode == M_PLAY || mode == M_WAIT));
        chk("win", 32'(bus.win), 32'(mode == M_WIN));
        chk("lose", 32'(bus.lose), 32'(mode == M_LOSE));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic press(input logic [3:0] b);
        bus.btn = b;
        step();
        bus.btn = 4'b0000;
    endtask

    task automatic run_to_wait();
        int n;
        n = 0;
        while (mode != M_WAIT && n < 200) begin
            step();
            n++;
        end
        chk("reach_wait_in", 32'(mode == M_WAIT), 32'd1);
    endtask

    task automatic start_round1(input logic [1:0] c);
        bus.rnd   = c;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
    endtask

    initial begin
        int r;

        bus.start = 1'b0;
        bus.btn   = 4'b0000;
        bus.rnd   = 2'd0;

        // Reset state
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_led", 32'(bus.led), 32'h0);
        chk("rst_level", 32'(bus.level), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        press(4'b0001);
        chk("idle_btn_busy", 32'(bus.busy), 32'h0);

        // First round: rnd=2
        bus.rnd   = 2'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_busy", 32'(bus.busy), 32'h1);
        step();
        chk("r1_led_on0", 32'(bus.led), 32'h4);
        repeat (3) step();
        chk("r1_led_on3", 32'(bus.led), 32'h4);
        step();
        chk("r1_led_off0", 32'(bus.led), 32'h0);
        step();
        step();
        chk("r1_wait_level", 32'(bus.level), 32'h1);
        chk("r1_wait_busy", 32'(bus.busy), 32'h1);

        // Full win: 2,1,3
        press(4'b0100);
        bus.rnd = 2'd1;
        step();
        run_to_wait();
        press(4'b0100);
        press(4'b0010);
        bus.rnd = 2'd3;
        step();
        run_to_wait();
        press(4'b0100);
        press(4'b0010);
        press(4'b1000);
        chk("win_win", 32'(bus.win), 32'h1);
        chk("win_led", 32'(bus.led), 32'hf);
        chk("win_level", 32'(bus.level), 32'h3);
        chk("win_busy", 32'(bus.busy), 32'h0);

        // Wrong press in round 2 with seq=(2,1)
        start_round1(2'd2);
        run_to_wait();
        press(4'b0100);
        bus.rnd = 2'd1;
        step();
        run_to_wait();
        press(4'b0100);
        press(4'b0001);
        chk("wrong_lose", 32'(bus.lose), 32'h1);
        chk("wrong_led", 32'(bus.led), 32'h0);
        chk("wrong_level", 32'(bus.level), 32'h2);

        // Multi-button press, then restart with start+btn together
        start_round1(2'd0);
        run_to_wait();
        press(4'b0011);
        chk("multi_lose", 32'(bus.lose), 32'h1);
        bus.start = 1'b1;
        bus.btn   = 4'b0001;
        step();
        bus.start = 1'b0;
        bus.btn   = 4'b0000;
        chk("restart_lose", 32'(bus.lose), 32'h0);
        chk("restart_busy", 32'(bus.busy), 32'h1);
        step();
        chk("restart_level", 32'(bus.level), 32'h1);

        // Async reset in SHOW_ON
        run_to_wait();
        press(4'b0100);
        chk("pre_rst_lose", 32'(bus.lose), 32'h1);
        start_round1(2'd2);
        step();
        chk("pre_rst_led", 32'(bus.led), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_led", 32'(bus.led), 32'h0);
        chk("async_busy", 32'(bus.busy), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Randomised play against the model
        for (int c = 0; c < 4000; c++) begin
            bus.rnd   = 2'($urandom);
            bus.start = 1'b0;
            bus.btn   = 4'b0000;
            r = $urandom_range(0, 99);
            case (mode)
                M_IDLE, M_WIN, M_LOSE: begin
                    bus.start = (r < 30);
                    if ($urandom_range(0, 3) == 0) bus.btn = 4'($urandom);
                end
                M_WAIT: begin
                    if (r < 40)      bus.btn = 4'b0000;
                    else if (r < 92) bus.btn = onehot(seq[pos]);
                    else if (r < 96) bus.btn = onehot($urandom_range(0, 3));
                    else             bus.btn = 4'($urandom);
                    bus.start = ($urandom_range(0, 49) == 0);
                end
                default: begin
                    bus.start = ($urandom_range(0, 29) == 0);
                    if (r < 20) bus.btn = 4'($urandom);
                end
            endcase
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simon_sequencer.md
# simon_sequencer

Game controller for the memory game. It builds a random colour sequence one step per round, plays it back on the four LEDs, then checks the player's button presses against it. It sits between the button conditioning and random source on the input side and the LED and score display logic on the output side. It is the only block that sequences the game datapath.

## Interface
- MAX_LEN, 16: maximum sequence length. Reaching and correctly entering MAX_LEN steps wins. Legal range 2..64.
- SHOW_TICKS, 25000000: clock cycles each step's LED is lit during playback. Must be ≥1.
- GAP_TICKS, 12500000: clock cycles all LEDs are dark between playback steps. Must be ≥1.
- LW, $clog2(MAX_LEN+1): width of the level output. This is a derived parameter and must not be overridden.

Ports:
- clk  in  1  system clock; everything is on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that starts a new game; honoured only in IDLE, WIN or LOSE
- btn  in  4  debounced, single-cycle press pulses, one bit per colour
- rnd  in  2  free-running random colour index, sampled in ADD
- led  out  4  one-hot colour display, registered
- level  out  LW  current sequence length, registered
- busy  out  1  high in every state except IDLE, WIN and LOSE
- win  out  1  high while in WIN
- lose  out  1  high while in LOSE

## Operation
- Storage: seq memory of MAX_LEN×2-bit registers, len counter (0..MAX_LEN), idx counter (0..MAX_LEN-1), tick counter wide enough for max(SHOW_TICKS, GAP_TICKS).
- onehot(c) = 4'b0001 << c. For example, colour 0 gives 4'b0001.
- States: IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE.
- IDLE/WIN/LOSE + start:
  - len←0, idx←0.
  - win and lose are cleared.
  - → ADD.
- ADD:
  - seq[len]←rnd; len←len+1; idx←0; tick←0.
  - → SHOW_ON.
- SHOW_ON:
  - led = onehot(seq[idx]).
  - After SHOW_TICKS cycles: tick←0, → SHOW_OFF.
- SHOW_OFF:
  - led = 0.
  - After GAP_TICKS cycles:
    - if idx == len-1: idx←0, → WAIT_IN;
    - else: idx←idx+1, tick←0, → SHOW_ON.
- WAIT_IN:
  - led = 0.
  - btn == 0: stay.
  - btn not one-hot, or btn != onehot(seq[idx]): → LOSE.
  - Correct press with idx < len-1: idx←idx+1.
  - Correct press with idx == len-1:
    - if len == MAX_LEN: → WIN;
    - else: → ADD.
- btn is ignored in every state except WAIT_IN.
- start is ignored in ADD, SHOW_ON, SHOW_OFF and WAIT_IN.
- level = len at all times. It is not cleared on LOSE or WIN, so the final score stays visible.
- WIN: led = 4'b1111. LOSE: led = 4'b0000.
- rnd is sampled only in ADD. The stored sequence is never rewritten within a game.

## Timing
- Reset values: state IDLE, led 0, level 0, busy 0, win 0, lose 0, all counters 0. seq contents are don't-care.
- Reset mid-operation forces the reset values immediately and asynchronously; no partial game survives.
- Start latency: the edge that samples start enters ADD (busy=1 from that edge). The next edge enters SHOW_ON, and led is nonzero from that edge onward.
- Each playback step: led lit for exactly SHOW_TICKS cycles, then dark for exactly GAP_TICKS cycles. The last step's gap also runs before WAIT_IN.
- A press is evaluated on the edge that samples it. LOSE, WIN or ADD is entered on that edge, and outputs update on that edge.
- Round restart: after a correct final press, ADD lasts 1 cycle. The next playback begins on the following edge, with no extra gap.
- Simultaneous press pulses on btn in the same cycle are treated as wrong (LOSE).
- start and btn asserted together in IDLE/WIN/LOSE: start wins and btn is ignored.

## Test plan
Bench parameters: MAX_LEN=3, SHOW_TICKS=4, GAP_TICKS=2.
- Reset check: hold rst_n=0 then release → led=0, level=0, busy=0, win=0, lose=0. Pulse btn=4'b0001 in IDLE → no state change.
- First round: rnd=2, pulse start → busy=1 next edge. led=4'b0100 for exactly 4 cycles, then 0 for 2 cycles. Then WAIT_IN with level=1.
- Full win: rnd=2,1,3 across rounds. Answer each round correctly: (0100), then (0100,0010), then (0100,0010,1000) → win=1, led=4'b1111, level=3, busy=0.
- Wrong press: in round 2 with seq=(2,1), press 4'b0100 then 4'b0001 → lose=1 on the second press, led=0, level=2.
- Multi-button press: in WAIT_IN, btn=4'b0011 → lose=1. Then pulse start → lose=0, busy=1, level=1 after ADD.
- Async reset mid-game: deassert rst_n during SHOW_ON with led=4'b0100 → led=0 and busy=0 immediately, without waiting for a clock edge.
